// File: rtl/vxe_axi4mas_biu.sv
// AXI4 master BIU: single-word queue requests become single-beat AXI4 transactions, one outstanding per path.
// Define VXE_AXI4MAS_BIU_ALIGN_EN to force AWADDR/ARADDR to word alignment.
module vxe_axi4mas_biu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int CID_WIDTH  = 8
) (
    input  logic                    M_AXI4_ACLK,
    input  logic                    M_AXI4_ARESETn,
    output logic [ID_WIDTH-1:0]     M_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR,
    output logic [7:0]              M_AXI4_AWLEN,
    output logic [2:0]              M_AXI4_AWSIZE,
    output logic [1:0]              M_AXI4_AWBURST,
    output logic                    M_AXI4_AWLOCK,
    output logic [3:0]              M_AXI4_AWCACHE,
    output logic [2:0]              M_AXI4_AWPROT,
    output logic                    M_AXI4_AWVALID,
    input  logic                    M_AXI4_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI4_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB,
    output logic                    M_AXI4_WLAST,
    output logic                    M_AXI4_WVALID,
    input  logic                    M_AXI4_WREADY,
    input  logic [ID_WIDTH-1:0]     M_AXI4_BID,
    input  logic [1:0]              M_AXI4_BRESP,
    input  logic                    M_AXI4_BVALID,
    output logic                    M_AXI4_BREADY,
    output logic [ID_WIDTH-1:0]     M_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR,
    output logic [7:0]              M_AXI4_ARLEN,
    output logic [2:0]              M_AXI4_ARSIZE,
    output logic [1:0]              M_AXI4_ARBURST,
    output logic                    M_AXI4_ARLOCK,
    output logic [3:0]              M_AXI4_ARCACHE,
    output logic [2:0]              M_AXI4_ARPROT,
    output logic                    M_AXI4_ARVALID,
    input  logic                    M_AXI4_ARREADY,
    input  logic [ID_WIDTH-1:0]     M_AXI4_RID,
    input  logic [DATA_WIDTH-1:0]   M_AXI4_RDATA,
    input  logic [1:0]              M_AXI4_RRESP,
    input  logic                    M_AXI4_RLAST,
    input  logic                    M_AXI4_RVALID,
    output logic                    M_AXI4_RREADY,
    input  logic [CID_WIDTH-1:0]    biu_awcid,
    input  logic [ADDR_WIDTH-1:0]   biu_awaddr,
    input  logic [DATA_WIDTH-1:0]   biu_awdata,
    input  logic [DATA_WIDTH/8-1:0] biu_awstrb,
    input  logic                    biu_awvalid,
    output logic                    biu_awpop,
    output logic [CID_WIDTH-1:0]    biu_bcid,
    output logic [1:0]              biu_bresp,
    input  logic                    biu_bready,
    output logic                    biu_bpush,
    input  logic [CID_WIDTH-1:0]    biu_arcid,
    input  logic [ADDR_WIDTH-1:0]   biu_araddr,
    input  logic                    biu_arvalid,
    output logic                    biu_arpop,
    output logic [CID_WIDTH-1:0]    biu_rcid,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic [1:0]              biu_rresp,
    input  logic                    biu_rready,
    output logic                    biu_rpush
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam int          SIZE_LOG2  = $clog2(STRB_WIDTH);
    localparam int unsigned MAP_WIDTH  = (ID_WIDTH < CID_WIDTH) ? ID_WIDTH : CID_WIDTH;
`ifdef VXE_AXI4MAS_BIU_ALIGN_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
`else
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = '1;
`endif

    typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP, WR_PUSH} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP, RD_PUSH} rd_state_t;

    function automatic logic [ID_WIDTH-1:0] cid_to_id(input logic [CID_WIDTH-1:0] c);
        logic [ID_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAP_WIDTH; i++) r[i] = c[i];
        return r;
    endfunction

    function automatic logic [CID_WIDTH-1:0] id_to_cid(input logic [ID_WIDTH-1:0] d);
        logic [CID_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAP_WIDTH; i++) r[i] = d[i];
        return r;
    endfunction

    logic rst;
    assign rst = M_AXI4_ARESETn;

    // ---------------- write path ----------------
    wr_state_t               wr_state, wr_next;
    logic                    aw_pend, w_pend;
    logic [CID_WIDTH-1:0]    aw_cid_q, bcid_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_WIDTH-1:0]   w_strb_q;
    logic [1:0]              bresp_q;
    logic                    wr_pop, wr_bready, wr_push;

    always_ff @(posedge M_AXI4_ACLK) begin
        if (rst) wr_state <= WR_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (biu_awvalid) wr_next = WR_REQ;
            WR_REQ:  if ((!aw_pend || M_AXI4_AWREADY) && (!w_pend || M_AXI4_WREADY)) wr_next = WR_RESP;
            WR_RESP: if (M_AXI4_BVALID) wr_next = WR_PUSH;
            WR_PUSH: if (biu_bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so they read 0 while reset is held.
    always_comb begin
        wr_pop    = 1'b0;
        wr_bready = 1'b0;
        wr_push   = 1'b0;
        case (wr_state)
            WR_IDLE: wr_pop    = !rst && biu_awvalid;
            WR_RESP: wr_bready = !rst;
            WR_PUSH: wr_push   = !rst && biu_bready;
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI4_ACLK) begin
        if (rst) begin
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            aw_cid_q  <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bcid_q    <= '0;
            bresp_q   <= '0;
        end else begin
            if (wr_pop) begin
                aw_pend   <= 1'b1;
                w_pend    <= 1'b1;
                aw_cid_q  <= biu_awcid;
                aw_addr_q <= biu_awaddr & ADDR_MASK;
                w_data_q  <= biu_awdata;
                w_strb_q  <= biu_awstrb;
            end else begin
                if (M_AXI4_AWREADY) aw_pend <= 1'b0;
                if (M_AXI4_WREADY)  w_pend  <= 1'b0;
            end
            if (wr_bready && M_AXI4_BVALID) begin
                bcid_q  <= id_to_cid(M_AXI4_BID);
                bresp_q <= M_AXI4_BRESP;
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t               rd_state, rd_next;
    logic                    ar_pend;
    logic [CID_WIDTH-1:0]    ar_cid_q, rcid_q;
    logic [ADDR_WIDTH-1:0]   ar_addr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic                    rd_pop, rd_rready, rd_push;

    always_ff @(posedge M_AXI4_ACLK) begin
        if (rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (biu_arvalid) rd_next = RD_REQ;
            RD_REQ:  if (!ar_pend || M_AXI4_ARREADY) rd_next = RD_RESP;
            RD_RESP: if (M_AXI4_RVALID) rd_next = RD_PUSH;
            RD_PUSH: if (biu_rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_pop    = 1'b0;
        rd_rready = 1'b0;
        rd_push   = 1'b0;
        case (rd_state)
            RD_IDLE: rd_pop    = !rst && biu_arvalid;
            RD_RESP: rd_rready = !rst;
            RD_PUSH: rd_push   = !rst && biu_rready;
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI4_ACLK) begin
        if (rst) begin
            ar_pend   <= 1'b0;
            ar_cid_q  <= '0;
            ar_addr_q <= '0;
            rcid_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            if (rd_pop) begin
                ar_pend   <= 1'b1;
                ar_cid_q  <= biu_arcid;
                ar_addr_q <= biu_araddr & ADDR_MASK;
            end else if (M_AXI4_ARREADY) begin
                ar_pend <= 1'b0;
            end
            if (rd_rready && M_AXI4_RVALID) begin
                rcid_q  <= id_to_cid(M_AXI4_RID);
                rdata_q <= M_AXI4_RDATA;
                rresp_q <= M_AXI4_RRESP;
            end
        end
    end

    // ---------------- outputs ----------------
    assign M_AXI4_AWID    = cid_to_id(aw_cid_q);
    assign M_AXI4_AWADDR  = aw_addr_q;
    assign M_AXI4_AWLEN   = 8'd0;
    assign M_AXI4_AWSIZE  = 3'(SIZE_LOG2);
    assign M_AXI4_AWBURST = 2'b01;
    assign M_AXI4_AWLOCK  = 1'b0;
    assign M_AXI4_AWCACHE = 4'b0000;
    assign M_AXI4_AWPROT  = 3'b000;
    assign M_AXI4_AWVALID = aw_pend;
    assign M_AXI4_WDATA   = w_data_q;
    assign M_AXI4_WSTRB   = w_strb_q;
    assign M_AXI4_WLAST   = 1'b1;
    assign M_AXI4_WVALID  = w_pend;
    assign M_AXI4_BREADY  = wr_bready;

    assign M_AXI4_ARID    = cid_to_id(ar_cid_q);
    assign M_AXI4_ARADDR  = ar_addr_q;
    assign M_AXI4_ARLEN   = 8'd0;
    assign M_AXI4_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI4_ARBURST = 2'b01;
    assign M_AXI4_ARLOCK  = 1'b0;
    assign M_AXI4_ARCACHE = 4'b0000;
    assign M_AXI4_ARPROT  = 3'b000;
    assign M_AXI4_ARVALID = ar_pend;
    assign M_AXI4_RREADY  = rd_rready;

    assign biu_awpop = wr_pop;
    assign biu_bcid  = bcid_q;
    assign biu_bresp = bresp_q;
    assign biu_bpush = wr_push;
    assign biu_arpop = rd_pop;
    assign biu_rcid  = rcid_q;
    assign biu_rdata = rdata_q;
    assign biu_rresp = rresp_q;
    assign biu_rpush = rd_push;

endmodule

// File: tb/tb_vxe_axi4mas_biu.sv
// Self-checking bench for vxe_axi4mas_biu: directed scenarios plus overlapping random read/write traffic.
module tb_vxe_axi4mas_biu;
    localparam int AW = 32, DW = 32, IW = 8, CW = 8, SW = DW / 8;
    localparam int BOUND = 40;

    logic clk = 1'b0, rst;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [3:0] awcache, arcache;
    logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [CW-1:0] b_awcid, b_bcid, b_arcid, b_rcid;
    logic [AW-1:0] b_awaddr, b_araddr;
    logic [DW-1:0] b_awdata, b_rdata;
    logic [SW-1:0] b_awstrb;
    logic [1:0] b_bresp, b_rresp;
    logic b_awvalid, b_awpop, b_bready, b_bpush, b_arvalid, b_arpop, b_rready, b_rpush;

    int n_checks = 0, n_errors = 0;

    vxe_axi4mas_biu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CID_WIDTH(CW)) dut (
        .M_AXI4_ACLK(clk), .M_AXI4_ARESETn(rst),
        .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen), .M_AXI4_AWSIZE(awsize),
        .M_AXI4_AWBURST(awburst), .M_AXI4_AWLOCK(awlock), .M_AXI4_AWCACHE(awcache), .M_AXI4_AWPROT(awprot),
        .M_AXI4_AWVALID(awvalid), .M_AXI4_AWREADY(awready),
        .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast), .M_AXI4_WVALID(wvalid),
        .M_AXI4_WREADY(wready), .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid),
        .M_AXI4_BREADY(bready),
        .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen), .M_AXI4_ARSIZE(arsize),
        .M_AXI4_ARBURST(arburst), .M_AXI4_ARLOCK(arlock), .M_AXI4_ARCACHE(arcache), .M_AXI4_ARPROT(arprot),
        .M_AXI4_ARVALID(arvalid), .M_AXI4_ARREADY(arready),
        .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp), .M_AXI4_RLAST(rlast),
        .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready),
        .biu_awcid(b_awcid), .biu_awaddr(b_awaddr), .biu_awdata(b_awdata), .biu_awstrb(b_awstrb),
        .biu_awvalid(b_awvalid), .biu_awpop(b_awpop), .biu_bcid(b_bcid), .biu_bresp(b_bresp),
        .biu_bready(b_bready), .biu_bpush(b_bpush),
        .biu_arcid(b_arcid), .biu_araddr(b_araddr), .biu_arvalid(b_arvalid), .biu_arpop(b_arpop),
        .biu_rcid(b_rcid), .biu_rdata(b_rdata), .biu_rresp(b_rresp), .biu_rready(b_rready),
        .biu_rpush(b_rpush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef VXE_AXI4MAS_BIU_ALIGN_EN
        return a & ~AW'(SW - 1);
`else
        return a;
`endif
    endfunction

    // {LEN, SIZE, BURST, LOCK, CACHE, PROT} for a single full-width incrementing beat
    localparam logic [20:0] AX_CONST = {8'd0, 3'($clog2(SW)), 2'b01, 1'b0, 4'd0, 3'd0};

    task automatic do_write(input logic [CW-1:0] cid, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [1:0] resp,
                            input int aw_dly, input int w_dly, input int b_dly, input int p_dly);
        logic aw_ok, w_ok;
        logic [IW-1:0] seen_id;
        int cyc;
        seen_id = '0;
        @(negedge clk);
        b_awcid = cid; b_awaddr = addr; b_awdata = data; b_awstrb = strb; b_awvalid = 1'b1;
        #1;
        chk("awpop", 64'(b_awpop), 64'd1);
        chk("awvalid_idle", 64'({awvalid, wvalid}), 64'd0);
        aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
        while (!(aw_ok && w_ok)) begin
            @(negedge clk);
            b_awvalid = 1'b0; b_awdata = DW'($urandom); b_awaddr = AW'($urandom);
            awready = (cyc >= aw_dly); wready = (cyc >= w_dly);
            #1;
            if (cyc == 0) chk("awpop_once", 64'(b_awpop), 64'd0);
            chk("bready_req", 64'(bready), 64'd0);
            if (!aw_ok) begin
                chk("awvalid", 64'(awvalid), 64'd1);
                if (awready) begin
                    aw_ok = 1'b1; seen_id = awid;
                    chk("awid", 64'(awid), 64'(cid));
                    chk("awaddr", 64'(awaddr), 64'(exp_addr(addr)));
                    chk("aw_const", 64'({awlen, awsize, awburst, awlock, awcache, awprot}), 64'(AX_CONST));
                end
            end else chk("awvalid_clr", 64'(awvalid), 64'd0);
            if (!w_ok) begin
                chk("wvalid", 64'(wvalid), 64'd1);
                if (wready) begin
                    w_ok = 1'b1;
                    chk("wdata", 64'(wdata), 64'(data));
                    chk("wstrb_wlast", 64'({wstrb, wlast}), 64'({strb, 1'b1}));
                end
            end else chk("wvalid_clr", 64'(wvalid), 64'd0);
            if (++cyc > BOUND) begin chk("wr_req_timeout", 64'd0, 64'd1); break; end
        end
        for (int i = 0; i <= b_dly; i++) begin
            @(negedge clk);
            awready = 1'b0; wready = 1'b0;
            bvalid = (i == b_dly); bid = seen_id; bresp = (i == b_dly) ? resp : 2'($urandom);
            #1;
            chk("bready", 64'(bready), 64'd1);
            chk("aw_w_idle", 64'({awvalid, wvalid}), 64'd0);
        end
        for (int i = 0; i <= p_dly; i++) begin
            @(negedge clk);
            bvalid = 1'b0; bid = IW'($urandom); bresp = 2'($urandom); b_bready = (i == p_dly);
            #1;
            chk("bready_push", 64'(bready), 64'd0);
            chk("bpush", 64'(b_bpush), 64'(i == p_dly));
            chk("bcid", 64'(b_bcid), 64'(cid));
            chk("bresp", 64'(b_bresp), 64'(resp));
        end
        @(negedge clk);
        b_bready = 1'($urandom);
        #1;
        chk("bpush_once", 64'({b_bpush, b_awpop}), 64'd0);
    endtask

    task automatic do_read(input logic [CW-1:0] cid, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [1:0] resp, input int ar_dly, input int r_dly, input int p_dly);
        logic ar_ok;
        logic [IW-1:0] seen_id;
        int cyc;
        seen_id = '0;
        @(negedge clk);
        b_arcid = cid; b_araddr = addr; b_arvalid = 1'b1;
        #1;
        chk("arpop", 64'(b_arpop), 64'd1);
        chk("arvalid_idle", 64'(arvalid), 64'd0);
        ar_ok = 1'b0; cyc = 0;
        while (!ar_ok) begin
            @(negedge clk);
            b_arvalid = 1'b0; b_araddr = AW'($urandom); arready = (cyc >= ar_dly);
            #1;
            if (cyc == 0) chk("arpop_once", 64'(b_arpop), 64'd0);
            chk("rready_req", 64'(rready), 64'd0);
            chk("arvalid", 64'(arvalid), 64'd1);
            if (arready) begin
                ar_ok = 1'b1; seen_id = arid;
                chk("arid", 64'(arid), 64'(cid));
                chk("araddr", 64'(araddr), 64'(exp_addr(addr)));
                chk("ar_const", 64'({arlen, arsize, arburst, arlock, arcache, arprot}), 64'(AX_CONST));
            end
            if (++cyc > BOUND) begin chk("rd_req_timeout", 64'd0, 64'd1); break; end
        end
        for (int i = 0; i <= r_dly; i++) begin
            @(negedge clk);
            arready = 1'b0;
            rvalid = (i == r_dly); rid = seen_id; rlast = 1'($urandom);
            rdata = (i == r_dly) ? data : DW'($urandom); rresp = (i == r_dly) ? resp : 2'($urandom);
            #1;
            chk("rready", 64'(rready), 64'd1);
            chk("arvalid_resp", 64'(arvalid), 64'd0);
        end
        for (int i = 0; i <= p_dly; i++) begin
            @(negedge clk);
            rvalid = 1'b0; rid = IW'($urandom); rdata = DW'($urandom); b_rready = (i == p_dly);
            #1;
            chk("rready_push", 64'(rready), 64'd0);
            chk("rpush", 64'(b_rpush), 64'(i == p_dly));
            chk("rcid", 64'(b_rcid), 64'(cid));
            chk("rdata_rresp", 64'({b_rdata, b_rresp}), 64'({data, resp}));
        end
        @(negedge clk);
        b_rready = 1'($urandom);
        #1;
        chk("rpush_once", 64'({b_rpush, b_arpop}), 64'd0);
    endtask

    task automatic reset_mid_resp();
        @(negedge clk);
        b_awcid = 8'h11; b_awaddr = 32'h100; b_awdata = 32'h1234_5678; b_awstrb = '1; b_awvalid = 1'b1;
        b_arcid = 8'h22; b_araddr = 32'h200; b_arvalid = 1'b1;
        #1;
        chk("rst_awpop", 64'({b_awpop, b_arpop}), 64'd3);
        @(negedge clk);
        b_awvalid = 1'b0; b_arvalid = 1'b0; awready = 1'b1; wready = 1'b1; arready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        #1;
        chk("rst_in_resp", 64'({bready, rready}), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bvalid = 1'b1; bid = 8'h11; rvalid = 1'b1; rid = 8'h22;
        #1;
        chk("rst_handshakes", 64'({awvalid, wvalid, arvalid, bready, rready, b_awpop, b_arpop, b_bpush, b_rpush}), 64'd0);
        chk("rst_regs", 64'({awaddr, wdata}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("late_resp_ignored", 64'({bready, rready, b_bpush, b_rpush}), 64'd0);
        end
        @(negedge clk);
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0;
        b_awcid = '0; b_awaddr = '0; b_awdata = '0; b_awstrb = '0; b_awvalid = 1'b0; b_bready = 1'b0;
        b_arcid = '0; b_araddr = '0; b_arvalid = 1'b0; b_rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids", 64'({awvalid, wvalid, arvalid, bready, rready, b_awpop, b_arpop, b_bpush, b_rpush}), 64'd0);
        chk("reset_regs", 64'({awaddr, wdata}), 64'd0);
        chk("reset_resp", 64'({b_bcid, b_bresp, b_rcid, b_rresp}), 64'd0);
        rst = 1'b0;

        do_write(8'hfe, 32'h0000_000c, 32'hfefe_fafa, 4'hf, 2'b00, 0, 0, 0, 0);
        do_read (8'hfa, 32'h0000_000b, 32'hfefe_fafa, 2'b00, 0, 0, 0);
        do_write(8'hfc, 32'h0000_f00c, 32'hdede_dada, 4'hf, 2'b00, 0, 0, 0, 3);
        do_read (8'hfd, 32'h0000_f00b, 32'hdede_dada, 2'b00, 0, 0, 3);
        do_write(8'h5a, 32'h0000_0040, 32'hcafe_f00d, 4'h3, 2'b10, 0, 3, 1, 0);
        reset_mid_resp();
        do_write(8'h33, 32'h0000_0080, 32'h0bad_beef, 4'hc, 2'b01, 1, 0, 0, 0);

        fork
            for (int i = 0; i < 40; i++)
                do_write(CW'($urandom), AW'($urandom), DW'($urandom), SW'($urandom), 2'($urandom),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            for (int j = 0; j < 40; j++)
                do_read(CW'($urandom), AW'($urandom), DW'($urandom), 2'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/vxe_axi4mas_biu.md
Name: vxe_axi4mas_biu

Overview:
AXI4 master bus interface unit. It converts single-word requests into single-beat AXI4 transactions. Requests come from FIFO-style pop interfaces: one write path and one independent read path. Responses go to FIFO-style push interfaces. It sits between the engine's internal request/response queues and the system AXI4 interconnect. Each path carries at most one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, AXI and BIU address width
DATA_WIDTH, 32, AXI and BIU data width (multiple of 8)
ID_WIDTH, 8, AXI ID width
CID_WIDTH, 8, BIU client ID width

Ports:
M_AXI4_ACLK  in  1  clock, all logic on rising edge
M_AXI4_ARESETn  in  1  reset, synchronous, active-high
M_AXI4_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWVALID  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI write address channel
M_AXI4_AWREADY  in  1  AW accept
M_AXI4_WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data channel
M_AXI4_WREADY  in  1  W accept
M_AXI4_BID/BRESP/BVALID  in  ID_WIDTH/2/1  AXI write response
M_AXI4_BREADY  out  1  B accept
M_AXI4_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARVALID  out  as AW  AXI read address channel
M_AXI4_ARREADY  in  1  AR accept
M_AXI4_RID/RDATA/RRESP/RLAST/RVALID  in  ID_WIDTH/DATA_WIDTH/2/1/1  AXI read data
M_AXI4_RREADY  out  1  R accept
biu_awcid/awaddr/awdata/awstrb  in  CID_WIDTH/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  write request at queue head
biu_awvalid  in  1  write queue non-empty
biu_awpop  out  1  pop write queue
biu_bcid/bresp  out  CID_WIDTH/2  write response
biu_bready  in  1  response queue not full
biu_bpush  out  1  push write response
biu_arcid/araddr  in  CID_WIDTH/ADDR_WIDTH  read request at queue head
biu_arvalid  in  1  read queue non-empty
biu_arpop  out  1  pop read queue
biu_rcid/rdata/rresp  out  CID_WIDTH/DATA_WIDTH/2  read response
biu_rready  in  1  read response queue not full
biu_rpush  out  1  push read response

Behaviour:
- Constant outputs:
  - AxLEN=0, AxSIZE=log2(DATA_WIDTH/8), AxBURST=2'b01, AxLOCK=0, AxCACHE=4'b0000, AxPROT=3'b000, WLAST=1.
- ID mapping:
  - AxID = cid, zero-extended or truncated to ID_WIDTH.
  - biu_bcid/biu_rcid = BID/RID, zero-extended or truncated to CID_WIDTH.
- Write FSM states: IDLE, REQ, RESP, PUSH.
  - IDLE: biu_awpop = biu_awvalid (combinational). On pop, register cid/addr/data/strb and set AWVALID=WVALID=1 from the next cycle; go to REQ.
  - REQ: AWVALID clears on AWVALID&AWREADY and WVALID clears on WVALID&WREADY, each independently and in any order. When both are done, go to RESP.
  - RESP: BREADY=1. On BVALID, capture BID/BRESP and go to PUSH. BREADY=0 in all other states.
  - PUSH: biu_bpush = biu_bready (combinational). biu_bcid/biu_bresp stay stable until the push. On push, return to IDLE.
- Read FSM states: IDLE, REQ, RESP, PUSH. It mirrors the write FSM:
  - arpop in IDLE.
  - ARVALID in REQ until ARREADY.
  - RREADY=1 in RESP; capture RID/RDATA/RRESP on RVALID. RLAST is ignored.
  - rpush = biu_rready in PUSH.
- The read and write paths are fully independent and may overlap.
- Minimum latency: pop at cycle 0; AxVALID at cycle 1; with zero-wait slave, push 1 cycle after the B/R handshake if the queue is ready.
- A new request is not popped until the previous response has been pushed.
- Reset:
  - Both FSMs return to IDLE.
  - All VALID/READY outputs, pop and push go to 0.
  - Registered address, data, strobe and response outputs go to 0.
  - Reset mid-transaction abandons the transaction; B/R responses arriving later stay unaccepted (BREADY/RREADY stay 0) until a new transaction reaches RESP.
- Address is passed unmodified unless the optional feature is enabled.

Optional Feature:
VXE_AXI4MAS_BIU_ALIGN_EN: when defined, the low log2(DATA_WIDTH/8) bits of AWADDR/ARADDR are forced to 0 (word-aligned). When undefined, addresses pass through unchanged.

Test Plan:
- Write cid=8'hfe, addr=32'h0000_000c, data=32'hfefe_fafa, biu_bready=1, slave always ready, BRESP=0 → AWID=8'hfe, AWADDR=0x0c, WDATA=32'hfefe_fafa, one awpop pulse, then one bpush with bcid=8'hfe, bresp=0.
- Read cid=8'hfa, addr=32'h0000_000b, biu_rready=1, slave returns last written data → ARID=8'hfa, ARADDR=0x0b (0x08 with ALIGN_EN), rpush with rcid=8'hfa, rdata=32'hfefe_fafa.
- Write cid=8'hfc, addr=0xf00c, data=32'hdede_dada with biu_bready=0 → B captured, bpush stays 0 and bcid holds 8'hfc; raising biu_bready gives a single bpush.
- Read cid=8'hfd, addr=0xf00b with biu_rready=0 → rpush withheld; raising biu_rready gives a single rpush with rcid=8'hfd.
- Slave holds AWREADY=1 but delays WREADY by 3 cycles → AWVALID drops after 1 cycle, WVALID holds 4 cycles, BREADY asserted only afterwards.
- Assert reset during RESP → all valids, pops and pushes read 0 the next cycle; a subsequent write completes normally.
